// File: rtl/shaper_peak_search_pkg.sv
// shaper_peak_search_pkg: shared widths and FSM state type for the peak search channel
package shaper_peak_search_pkg;
  localparam int SIZE_SHAPER_DATA = 16;
  localparam int SIZE_TIME_MAXIMUM_SEARCH = 8;
  localparam int ZERO_LINE_LOG2 = 8;
  localparam int SIZE_EVENT_COUNTER = 32;
  typedef enum logic [2:0] {ZERO_LINE, WAIT_TRIGGER, SEARCH, REPORT, HOLDOFF} peak_search_state_t;
endpackage

// File: rtl/shaper_peak_search_if.sv
// shaper_peak_search_if: shaper sample input, controls and peak report outputs of one channel
interface shaper_peak_search_if;
  import shaper_peak_search_pkg::*;
  logic enable;
  logic [SIZE_SHAPER_DATA-1:0] shaper_data;
  logic shaper_data_valid;
  logic [SIZE_SHAPER_DATA-1:0] threshold;
  logic [SIZE_TIME_MAXIMUM_SEARCH-1:0] search_time;
  logic [SIZE_SHAPER_DATA-1:0] zero_line;
  logic zero_line_valid;
  logic [SIZE_SHAPER_DATA-1:0] amplitude;
  logic amplitude_valid;
  logic pile_up;
  logic [SIZE_EVENT_COUNTER-1:0] event_counter;
  logic busy;
  modport master (
    output enable, shaper_data, shaper_data_valid, threshold, search_time,
    input zero_line, zero_line_valid, amplitude, amplitude_valid, pile_up, event_counter, busy
  );
  modport slave (
    input enable, shaper_data, shaper_data_valid, threshold, search_time,
    output zero_line, zero_line_valid, amplitude, amplitude_valid, pile_up, event_counter, busy
  );
endinterface

// File: rtl/shaper_peak_search_zero_line_meter.sv
// shaper_peak_search_zero_line_meter: sums 2**ZERO_LINE_LOG2 samples and yields their arithmetic mean
module shaper_peak_search_zero_line_meter
  import shaper_peak_search_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic accumulate,
  input  logic [SIZE_SHAPER_DATA-1:0] sample,
  output logic done,
  output logic [SIZE_SHAPER_DATA-1:0] mean
);
  localparam int W = SIZE_SHAPER_DATA + ZERO_LINE_LOG2;
  logic [W-1:0] acc, sum;
  logic [ZERO_LINE_LOG2-1:0] cnt;
  assign sum = acc + {{ZERO_LINE_LOG2{sample[SIZE_SHAPER_DATA-1]}}, sample};
  assign done = accumulate && &cnt;
  // the upper bits of the sum are the arithmetic right shift by ZERO_LINE_LOG2
  assign mean = sum[W-1:ZERO_LINE_LOG2];
  always_ff @(posedge clk)
    if (reset || clear || done) begin
      acc <= '0;
      cnt <= '0;
    end else if (accumulate) begin
      acc <= sum;
      cnt <= cnt + ZERO_LINE_LOG2'(1);
    end
endmodule

// File: rtl/shaper_peak_search.sv
// shaper_peak_search: zero-line tracking, threshold trigger and windowed peak search per channel
module shaper_peak_search
  import shaper_peak_search_pkg::*;
(
  input logic clk,
  input logic reset,
  shaper_peak_search_if.slave bus
);
  localparam int SD = SIZE_SHAPER_DATA;
  localparam int ST = SIZE_TIME_MAXIMUM_SEARCH;
  peak_search_state_t state;
  logic signed [SD:0] diff, peak;
  logic [SD-1:0] thr_q, thr_sel, zl_mean;
  logic [ST-1:0] win_cnt;
  logic above, below_seen, pile_int, zl_done, zl_acc, zl_clear, trigger;
  assign diff = {bus.shaper_data[SD-1], bus.shaper_data} - {bus.zero_line[SD-1], bus.zero_line};
  // live threshold arms the trigger; the latched copy governs the rest of the pulse
  assign thr_sel = state == WAIT_TRIGGER ? bus.threshold : thr_q;
  assign above = diff > $signed({1'b0, thr_sel});
  assign trigger = state == WAIT_TRIGGER && bus.shaper_data_valid && above;
  assign zl_acc = bus.enable && bus.shaper_data_valid &&
                  (state == ZERO_LINE || (state == WAIT_TRIGGER && !above));
  assign zl_clear = !bus.enable || trigger;
  assign bus.busy = state inside {SEARCH, REPORT, HOLDOFF};
  shaper_peak_search_zero_line_meter meter (
    .clk(clk),
    .reset(reset),
    .clear(zl_clear),
    .accumulate(zl_acc),
    .sample(bus.shaper_data),
    .done(zl_done),
    .mean(zl_mean)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= ZERO_LINE;
      peak <= '0;
      thr_q <= '0;
      win_cnt <= '0;
      below_seen <= 1'b0;
      pile_int <= 1'b0;
      bus.zero_line <= '0;
      bus.zero_line_valid <= 1'b0;
      bus.amplitude <= '0;
      bus.amplitude_valid <= 1'b0;
      bus.pile_up <= 1'b0;
      bus.event_counter <= '0;
    end else if (!bus.enable) begin
      state <= ZERO_LINE;
      win_cnt <= '0;
      bus.zero_line_valid <= 1'b0;
      bus.amplitude_valid <= 1'b0;
    end else begin
      bus.amplitude_valid <= 1'b0;
      if (zl_done) begin
        bus.zero_line <= zl_mean;
        bus.zero_line_valid <= 1'b1;
      end
      case (state)
        ZERO_LINE: if (zl_done) state <= WAIT_TRIGGER;
        WAIT_TRIGGER: if (trigger) begin
          state <= SEARCH;
          peak <= diff;
          thr_q <= bus.threshold;
          win_cnt <= bus.search_time == '0 ? '0 : bus.search_time - ST'(1);
          below_seen <= 1'b0;
          pile_int <= 1'b0;
        end
        SEARCH: if (bus.shaper_data_valid) begin
          if (diff > peak) peak <= diff;
          if (!above) below_seen <= 1'b1;
          else if (below_seen) pile_int <= 1'b1;
          if (win_cnt == '0) state <= REPORT;
          else win_cnt <= win_cnt - ST'(1);
        end
        REPORT: begin
          bus.amplitude <= peak[SD] ? '0 : peak[SD-1:0];
          bus.pile_up <= pile_int;
          bus.amplitude_valid <= 1'b1;
          bus.event_counter <= bus.event_counter + SIZE_EVENT_COUNTER'(1);
          state <= HOLDOFF;
        end
        HOLDOFF: if (bus.shaper_data_valid && !above) state <= WAIT_TRIGGER;
        default: state <= ZERO_LINE;
      endcase
    end
endmodule

// File: tb/tb_shaper_peak_search.sv
// tb_shaper_peak_search: directed and randomized stimulus against a sample-level behavioural model
module tb_shaper_peak_search;
  import shaper_peak_search_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  shaper_peak_search_if bus();
  shaper_peak_search dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0;
  int checks = 0;
  int phase, m_zl, m_n, m_thr, m_rem, m_peak, m_amp;
  longint m_sum;
  bit m_zlv, m_av, m_pu, m_below, m_pile;
  logic [31:0] m_cnt;
  int pulse_a[12] = '{200, 500, 800, 1000, 900, 700, 500, 300, 100, 0, 0, 0};
  int pulse_b[12] = '{400, 700, 20, 500, 1200, 800, 200, 0, 0, 0, 0, 0};
  int pulse_c[9] = '{0, 0, 300, 900, 500, 0, 0, 0, 0};
  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  // phases: 0 measuring, 1 waiting, 2 in window, 3 report due, 4 waiting for pulse to fall
  task automatic model_step();
    int diff, t;
    bit ab;
    m_av = 1'b0;
    if (reset) begin
      phase = 0; m_zl = 0; m_zlv = 0; m_amp = 0; m_pu = 0; m_cnt = 0; m_sum = 0; m_n = 0;
      return;
    end
    if (!bus.enable) begin
      phase = 0; m_sum = 0; m_n = 0; m_zlv = 0;
      return;
    end
    diff = int'($signed(bus.shaper_data)) - m_zl;
    t = (phase == 1) ? int'(bus.threshold) : m_thr;
    ab = diff > t;
    if (phase == 3) begin
      m_amp = m_peak < 0 ? 0 : (m_peak > 65535 ? 65535 : m_peak);
      m_pu = m_pile; m_av = 1; m_cnt++; phase = 4;
    end else if (bus.shaper_data_valid) begin
      if (phase == 1 && ab) begin
        phase = 2; m_peak = diff; m_thr = t; m_below = 0; m_pile = 0; m_sum = 0; m_n = 0;
        m_rem = bus.search_time == 0 ? 1 : int'(bus.search_time);
      end else if (phase <= 1) begin
        m_sum += longint'($signed(bus.shaper_data));
        m_n++;
        if (m_n == (1 << ZERO_LINE_LOG2)) begin
          m_zl = int'(m_sum >>> ZERO_LINE_LOG2); m_zlv = 1; m_sum = 0; m_n = 0; phase = 1;
        end
      end else if (phase == 2) begin
        if (diff > m_peak) m_peak = diff;
        if (!ab) m_below = 1;
        else if (m_below) m_pile = 1;
        m_rem--;
        if (m_rem == 0) phase = 3;
      end else if (!ab) phase = 1;
    end
  endtask
  task automatic tick(int dv, bit vv);
    bus.shaper_data = 16'(dv);
    bus.shaper_data_valid = vv;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("zero_line", longint'($signed(bus.zero_line)), m_zl);
    chk("zero_line_valid", bus.zero_line_valid, m_zlv);
    chk("amplitude", longint'(bus.amplitude), m_amp);
    chk("amplitude_valid", bus.amplitude_valid, m_av);
    chk("pile_up", bus.pile_up, m_pu);
    chk("event_counter", longint'(bus.event_counter), m_cnt);
    chk("busy", bus.busy, phase >= 2);
  endtask
  function automatic int noise(int n);
    return int'($urandom_range(0, 2 * n)) - n;
  endfunction
  int base, pamp;
  initial begin
    bus.enable = 1'b0; bus.threshold = 16'd50; bus.search_time = 8'd8;
    bus.shaper_data = '0; bus.shaper_data_valid = 1'b0;
    @(negedge clk);
    repeat (3) tick(0, 0);
    chk("reset_event_counter", longint'(bus.event_counter), 0);
    reset = 1'b0;
    bus.enable = 1'b1;
    repeat (255) tick(100, 1);
    chk("zlv_before_256", bus.zero_line_valid, 0);
    tick(100, 1);
    chk("zlv_after_256", bus.zero_line_valid, 1);
    chk("zl_100", longint'($signed(bus.zero_line)), 100);
    repeat (40) tick(100, 1);
    chk("no_event_on_flat", longint'(bus.event_counter), 0);
    foreach (pulse_a[i]) tick(100 + pulse_a[i], 1);
    repeat (5) tick(100, 1);
    chk("single_amp", longint'(bus.amplitude), 1000);
    chk("single_pile", bus.pile_up, 0);
    chk("single_events", longint'(bus.event_counter), 1);
    foreach (pulse_b[i]) tick(100 + pulse_b[i], 1);
    repeat (5) tick(100, 1);
    chk("pile_amp", longint'(bus.amplitude), 1200);
    chk("pile_flag", bus.pile_up, 1);
    chk("pile_events", longint'(bus.event_counter), 2);
    bus.enable = 1'b0;
    repeat (2) tick(0, 0);
    chk("zlv_disabled", bus.zero_line_valid, 0);
    bus.enable = 1'b1;
    repeat (256) tick(-200, 1);
    chk("zl_neg", longint'($signed(bus.zero_line)), -200);
    tick(32767, 1);
    repeat (12) tick(-200, 1);
    chk("big_amp", longint'(bus.amplitude), 32967);
    bus.threshold = 16'd30; bus.search_time = 8'd2;
    tick(40, 1);
    repeat (6) tick(-200, 1);
    chk("small_amp", longint'(bus.amplitude), 240);
    bus.threshold = 16'd50; bus.search_time = 8'd0;
    foreach (pulse_c[i]) begin
      tick(-200 + pulse_c[i], 1);
      repeat (2) tick(int'($urandom_range(0, 30000)), 0);
    end
    chk("sparse_amp", longint'(bus.amplitude), 900);
    chk("sparse_events", longint'(bus.event_counter), 5);
    bus.search_time = 8'd8;
    tick(300, 1);
    tick(600, 1);
    chk("busy_in_search", bus.busy, 1);
    bus.enable = 1'b0;
    tick(600, 1);
    chk("abort_zlv", bus.zero_line_valid, 0);
    chk("abort_busy", bus.busy, 0);
    repeat (3) tick(600, 1);
    bus.enable = 1'b1;
    repeat (256) tick(50, 1);
    chk("remeasure_zl", longint'($signed(bus.zero_line)), 50);
    chk("abort_events", longint'(bus.event_counter), 5);
    base = int'($urandom_range(0, 2000)) - 1000;
    pamp = 0;
    repeat (260) tick(base + noise(3), 1);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) == 0) bus.threshold = 16'($urandom_range(20, 300));
      if ($urandom_range(0, 49) == 0) bus.search_time = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 1999) == 0) begin
        bus.enable = 1'b0;
        repeat (3) tick(base, 1);
        bus.enable = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(0, 30000)), 0);
      else begin
        if ($urandom_range(0, 29) == 0) pamp += int'($urandom_range(100, 12000));
        if (pamp > 30000) pamp = 30000;
        tick(base + noise(3) + pamp, 1);
        pamp = pamp * 3 / 4;
      end
    end
    bus.enable = 1'b0;
    tick(0, 0);
    bus.enable = 1'b1; bus.threshold = 16'd50; bus.search_time = 8'd8;
    repeat (256) tick(0, 1);
    tick(1000, 1);
    chk("busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    repeat (2) tick(1000, 1);
    chk("reset_events", longint'(bus.event_counter), 0);
    chk("reset_amp", longint'(bus.amplitude), 0);
    chk("reset_av", bus.amplitude_valid, 0);
    chk("reset_busy", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
